// File: rtl/bank_read_sequencer.sv
// rtl/bank_read_sequencer.sv - two-requester round-robin byte read sequencer for the four-bank byte mux
//
// Accepts a start byte address and length from each of two requesters and
// arbitrates between them round-robin. It steps the mux bank/byte select one
// byte per cycle and realigns the mux's registered output into a tagged byte
// stream.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid[1:0]         per-requester request, held until granted
//   req_addr0/1 [3:0]      start byte address {bank, byte}
//   req_len0/1 [LEN_W-1:0] byte count (0 is treated as 1)
//   req_grant[1:0]         one-hot acceptance strobe; addr/len sampled at the end of this cycle
//   bank_sel/byte_sel      mux select, registered, held when idle
//   mux_data[7:0]          mux output, valid the cycle after sel is sampled
//   byte_valid/data/src/last  output byte stream, no backpressure
//   busy                   high from the cycle after grant until the last byte is delivered
module bank_read_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [3:0]       req_addr0,
  input  logic [3:0]       req_addr1,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       req_grant,
  output logic [1:0]       bank_sel,
  output logic [1:0]       byte_sel,
  input  logic [7:0]       mux_data,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_src,
  output logic             byte_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state;
  logic [3:0]       addr;     // {bank_sel, byte_sel} currently presented to the mux
  logic [LEN_W-1:0] cnt;      // bytes still to present, including the current one
  logic             pref;     // requester that wins when both are pending
  logic             src;      // owner of the burst in progress
  logic [LEN_W-1:0] len_pick;
  logic [1:0]       grant_c;

  // Issue-side tags; they travel two stages to line up with byte_data
  // (stage 1 matches mux_data, stage 2 matches the byte_data register).
  logic             issued;
  logic             issued_last;
  logic             v1;
  logic             s1;
  logic             l1;

  assign bank_sel = addr[3:2];
  assign byte_sel = addr[1:0];

  // The grant decision is made in the IDLE cycle itself so that the select is
  // already on the mux in the following cycle; this gives the 3-cycle
  // grant-to-first-byte latency.
  always_comb begin
    grant_c = 2'b00;
    if (state == IDLE && !rst) begin
      if (req_valid == 2'b11)
        grant_c = pref ? 2'b10 : 2'b01;
      else
        grant_c = req_valid;
    end
  end

  assign req_grant   = grant_c;
  assign len_pick    = grant_c[1] ? req_len1 : req_len0;
  assign issued      = (state == ISSUE);
  assign issued_last = (state == ISSUE) && (cnt == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= 4'h0;
      cnt   <= '0;
      pref  <= 1'b0;
      src   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_c != 2'b00) begin
            src   <= grant_c[1];
            addr  <= grant_c[1] ? req_addr1 : req_addr0;
            cnt   <= (len_pick == '0) ? LEN_W'(1) : len_pick;
            pref  <= ~grant_c[1];
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Last byte address stays on the mux while the pipe drains.
          if (cnt == LEN_W'(1)) begin
            state <= DRAIN;
          end else begin
            addr <= addr + 4'd1;
            cnt  <= cnt - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (byte_valid && byte_last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      s1         <= 1'b0;
      l1         <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_src   <= 1'b0;
      byte_last  <= 1'b0;
    end else begin
      v1         <= issued;
      s1         <= src;
      l1         <= issued_last;
      byte_valid <= v1;
      byte_src   <= s1;
      byte_last  <= v1 && l1;
      if (v1)
        byte_data <= mux_data;
    end
  end

endmodule
